cpu_control: RTL

CPU_CONTROL -- requirements
Module: cpu_control

---
 rtl/cpu_control.sv | 106 ++++++++++
 1 files changed

// File: rtl/cpu_control.sv
// CPU control register block: Wishbone B4 pipelined responder with one control register
// and a stretched CPU reset that guarantees a minimum hold time per assertion.
module cpu_control #(
  parameter int RESET_MIN_CYCLES = 128,
  parameter int REG_ADDR_WIDTH   = 1
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [7:0]                wb_dat_i,
  output logic [7:0]                wb_dat_o,
  input  logic                      wb_we_i,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  output logic                      wb_stall_o,
  output logic                      wb_ack_o,
  output logic                      cpu_ready_o,
  output logic                      cpu_reset_o
);

  localparam int CNT_W = (RESET_MIN_CYCLES > 1) ? $clog2(RESET_MIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RESET_MIN_CYCLES - 1);

  typedef enum logic {BUS_IDLE, BUS_ACK} bus_state_e;
  typedef enum logic {RST_HOLD, RST_RUN} rst_state_e;

  bus_state_e       bus_q, bus_d;
  rst_state_e       rst_q, rst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             rst_bit_q, rst_bit_d;
  logic [7:0]       rdata_q, rdata_d;

  logic accept, reg_sel, wr_cpu, set_rst, hold;
  logic unused_wdata;

  assign hold    = (rst_q == RST_HOLD);
  assign accept  = wb_cyc_i & wb_stb_i & (bus_q == BUS_IDLE);
  assign reg_sel = (wb_adr_i == '0);
  assign wr_cpu  = accept & wb_we_i & reg_sel;
  assign set_rst = wr_cpu & wb_dat_i[1];

  // Bits 7:2 of REG_CPU are not writable.
  assign unused_wdata = ^wb_dat_i[7:2];

  always_comb begin
    bus_d     = bus_q;
    rdata_d   = rdata_q;
    ready_d   = ready_q;
    rst_bit_d = rst_bit_q;
    case (bus_q)
      BUS_IDLE: if (accept) bus_d = BUS_ACK;
      BUS_ACK:  bus_d = BUS_IDLE;
      default:  bus_d = BUS_IDLE;
    endcase
    if (accept) begin
      rdata_d = reg_sel ? {5'b0, hold, rst_bit_q, ready_q} : 8'h00;
    end
    if (wr_cpu) begin
      ready_d   = wb_dat_i[0];
      rst_bit_d = wb_dat_i[1];
    end
  end

  // Any write of RESET=1 (re)starts a full minimum-length hold, even if already holding.
  always_comb begin
    rst_d = rst_q;
    cnt_d = cnt_q;
    if (set_rst) begin
      rst_d = RST_HOLD;
      cnt_d = '0;
    end else if (rst_q == RST_HOLD) begin
      if (cnt_q == CNT_MAX) begin
        if (!rst_bit_q) rst_d = RST_RUN;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      bus_q     <= BUS_IDLE;
      rst_q     <= RST_HOLD;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      rst_bit_q <= 1'b1;
      rdata_q   <= 8'h00;
    end else begin
      bus_q     <= bus_d;
      rst_q     <= rst_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      rst_bit_q <= rst_bit_d;
      rdata_q   <= rdata_d;
    end
  end

  // reset_i gates the outputs directly so an in-flight ACK is dropped on the reset cycle.
  assign wb_stall_o  = (bus_q == BUS_ACK) & ~reset_i;
  assign wb_ack_o    = (bus_q == BUS_ACK) & wb_cyc_i & ~reset_i;
  assign wb_dat_o    = wb_ack_o ? rdata_q : 8'h00;
  assign cpu_reset_o = hold | reset_i;
  assign cpu_ready_o = ready_q & ~cpu_reset_o;

endmodule
